// File: rtl/epcs_pkg.sv
// Opcodes and FSM state type shared by the EPCS responder.
// Defining EPCS_STATUS_EN adds the read-status state and its status byte.
package epcs_pkg;

    localparam logic [7:0] OP_FAST_READ   = 8'h0B;
    localparam logic [7:0] OP_READ        = 8'h03;
    localparam logic [7:0] OP_READ_STATUS = 8'h05;

`ifdef EPCS_STATUS_EN
    // WIP=0: the emulated device is never busy.
    localparam logic [7:0] STATUS_BYTE = 8'h00;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
`ifdef EPCS_STATUS_EN
        , ST_STATUS
`endif
    } state_e;

endpackage

// File: rtl/epcs_if.sv
// EPCS serial bus plus the byte-read port to the backing store.
// The master modport is the flash controller / memory side; slave is the responder.
interface epcs_if #(
    parameter int ADDR_BITS = 24
);
    logic                 EPCS_CSN;
    logic                 EPCS_DCLK;
    logic                 EPCS_ASDI;
    logic                 EPCS_DATA;
    logic                 MEM_RD;
    logic [ADDR_BITS-1:0] MEM_ADDR;
    logic [7:0]           MEM_DATA;
    logic                 CMD_ERR;

    modport master (
        output EPCS_CSN, EPCS_DCLK, EPCS_ASDI, MEM_DATA,
        input  EPCS_DATA, MEM_RD, MEM_ADDR, CMD_ERR
    );

    modport slave (
        input  EPCS_CSN, EPCS_DCLK, EPCS_ASDI, MEM_DATA,
        output EPCS_DATA, MEM_RD, MEM_ADDR, CMD_ERR
    );
endinterface

// File: rtl/epcs_edge_det.sv
// Registers DCLK/CSN and derives single-cycle edge pulses, qualified by chip select.
module epcs_edge_det (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic csn,
    input  logic dclk,
    output logic selected,
    output logic csn_fall,
    output logic dclk_rise,
    output logic dclk_fall
);
    logic csn_q;
    logic dclk_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            // Previous CSN reads as "already low" so a reset released mid-transfer
            // never looks like a fresh select.
            csn_q  <= 1'b0;
            dclk_q <= 1'b1;
        end else begin
            csn_q  <= csn;
            dclk_q <= dclk;
        end
    end

    assign selected  = ~csn;
    assign csn_fall  = ~csn & csn_q;
    assign dclk_rise = ~csn & dclk & ~dclk_q;
    assign dclk_fall = ~csn & ~dclk & dclk_q;
endmodule

// File: rtl/epcs_responder.sv
// EPCS flash slave model: decodes Read/Fast Read, streams bytes fetched from a backing store.
// Defining EPCS_STATUS_EN adds Read Status (0x05), which streams a constant status byte.
module epcs_responder
    import epcs_pkg::*;
#(
    parameter int ADDR_BITS  = 24,
    parameter int DUMMY_BITS = 8
) (
    input logic   SIM_CLK,
    input logic   SIM_RST,
    epcs_if.slave bus
);
    localparam int MAX_BITS = (ADDR_BITS > DUMMY_BITS) ? ADDR_BITS : DUMMY_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    state_e               state_q, state_d;
    logic                 selected, csn_fall, dclk_rise, dclk_fall;
    logic [CNT_W-1:0]     bit_cnt;
    logic [ADDR_BITS-2:0] sr_in;
    logic [7:0]           opcode;
    logic [ADDR_BITS-1:0] addr_in;
    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic                 fast_q;
    logic [7:0]           sr_out;
    logic [7:0]           nxt_byte;
    logic [7:0]           reload;
    logic [2:0]           out_cnt;
    logic                 first_byte;
    logic                 load_q;
    logic                 mem_rd_q;
    logic                 data_q;
    logic                 cmd_err_q;
    logic                 cmd_err_d;
    logic                 op_done;
    logic                 addr_done;
    logic                 shift_state;

    epcs_edge_det u_edge (
        .SIM_CLK   (SIM_CLK),
        .SIM_RST   (SIM_RST),
        .csn       (bus.EPCS_CSN),
        .dclk      (bus.EPCS_DCLK),
        .selected  (selected),
        .csn_fall  (csn_fall),
        .dclk_rise (dclk_rise),
        .dclk_fall (dclk_fall)
    );

    // The bit being sampled this cycle completes the opcode/address word.
    assign opcode  = {sr_in[6:0], bus.EPCS_ASDI};
    assign addr_in = {sr_in, bus.EPCS_ASDI};

`ifdef EPCS_STATUS_EN
    assign shift_state = (state_q == ST_DATA) || (state_q == ST_STATUS);
    assign reload      = (state_q == ST_STATUS) ? STATUS_BYTE : nxt_byte;
`else
    assign shift_state = (state_q == ST_DATA);
    assign reload      = nxt_byte;
`endif

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        cmd_err_d = 1'b0;
        op_done   = 1'b0;
        addr_done = 1'b0;
        if (!selected) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = csn_fall ? ST_OPCODE : ST_IGNORE;
                ST_OPCODE: begin
                    if (dclk_rise && bit_cnt == CNT_W'(7)) begin
                        op_done = 1'b1;
                        case (opcode)
                            OP_FAST_READ, OP_READ: state_d = ST_ADDR;
`ifdef EPCS_STATUS_EN
                            OP_READ_STATUS: state_d = ST_STATUS;
`else
                            OP_READ_STATUS: begin
                                state_d   = ST_IGNORE;
                                cmd_err_d = 1'b1;
                            end
`endif
                            default: begin
                                state_d   = ST_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (dclk_rise && bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                        addr_done = 1'b1;
                        state_d   = (fast_q && DUMMY_BITS > 0) ? ST_DUMMY : ST_DATA;
                    end
                end
                ST_DUMMY: begin
                    if (dclk_rise && bit_cnt == CNT_W'(DUMMY_BITS - 1)) state_d = ST_DATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            bit_cnt    <= '0;
            sr_in      <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            fast_q     <= 1'b0;
            sr_out     <= '0;
            nxt_byte   <= '0;
            out_cnt    <= '0;
            first_byte <= 1'b0;
            load_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            data_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            cmd_err_q <= cmd_err_d;
            mem_rd_q  <= 1'b0;
            load_q    <= mem_rd_q;

            if (state_d != state_q) bit_cnt <= '0;
            else if (dclk_rise)     bit_cnt <= bit_cnt + 1'b1;

            if (dclk_rise && (state_q == ST_OPCODE || state_q == ST_ADDR))
                sr_in <= {sr_in[ADDR_BITS-3:0], bus.EPCS_ASDI};

            if (op_done) fast_q <= (opcode == OP_FAST_READ);
`ifdef EPCS_STATUS_EN
            if (op_done && opcode == OP_READ_STATUS) sr_out <= STATUS_BYTE;
`endif

            if (addr_done) begin
                addr_q     <= addr_in;
                mem_addr_q <= addr_in;
                mem_rd_q   <= 1'b1;
                first_byte <= 1'b1;
            end

            // The first byte goes straight to the shifter; prefetched bytes wait in nxt_byte.
            if (load_q) begin
                if (first_byte) begin
                    sr_out     <= bus.MEM_DATA;
                    first_byte <= 1'b0;
                end else begin
                    nxt_byte <= bus.MEM_DATA;
                end
            end

            if (!shift_state) begin
                data_q  <= 1'b0;
                out_cnt <= '0;
            end else if (dclk_fall) begin
                data_q  <= sr_out[7];
                out_cnt <= out_cnt + 1'b1;
                sr_out  <= (out_cnt == 3'd7) ? reload : {sr_out[6:0], 1'b0};
                if (state_q == ST_DATA && out_cnt == 3'd0) begin
                    addr_q     <= addr_q + 1'b1;
                    mem_addr_q <= addr_q + 1'b1;
                    mem_rd_q   <= 1'b1;
                end
            end

            // Deselect cancels any strobe or load still in flight.
            if (!selected) begin
                mem_rd_q   <= 1'b0;
                load_q     <= 1'b0;
                first_byte <= 1'b0;
                data_q     <= 1'b0;
            end
        end
    end

    assign bus.EPCS_DATA = data_q;
    assign bus.MEM_RD    = mem_rd_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.CMD_ERR   = cmd_err_q;
endmodule
